// File: rtl/rom_loader_if.sv
// HPS download stream bundle: index/address/data with download and write qualifiers.
interface rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  // Source side (HPS / bench)
  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout
  );

  // Sink side (loader)
  modport slave (
    input ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout
  );
endinterface

// File: rtl/rom_loader.sv
// ROM loader: routes the HPS download stream into the CPU, sound and sample ROM
// write ports, captures DIP/game-select bytes, tracks load status and holds
// the game core in reset until a download has settled.
module rom_loader #(
  parameter int unsigned HOLD_CYCLES = 256
) (
  input  logic        clk_sys,
  input  logic        reset,
  rom_loader_if.slave ioctl,
  output logic        cpu_rom_we,
  output logic [14:0] cpu_rom_addr,
  output logic        snd_rom_we,
  output logic [11:0] snd_rom_addr,
  output logic        wav_rom_we,
  output logic [15:0] wav_rom_addr,
  output logic [7:0]  rom_data,
  output logic [7:0]  dip_sw,
  output logic [4:0]  game_mod,
  output logic        core_hold,
  output logic        rom_valid,
  output logic [17:0] byte_count,
  output logic [7:0]  checksum
);

  // A zero hold length still spends one cycle in HOLD.
  localparam int unsigned HOLD_EFF  = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int unsigned CNT_W     = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
  localparam int unsigned BC_W      = 18;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
  localparam logic [BC_W-1:0]  BC_MAX    = {BC_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    HOLD  = 2'd2,
    READY = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             dl_q;
  logic [7:0]       mod_q;

  logic             dl_rise_c, dl_fall_c, wr_acc_c;
  logic             sel_cpu_c, sel_snd_c, sel_wav_c, in_map_c;
  logic [BC_W-1:0]  bc_base_c, bc_n_c;
  logic [7:0]       cks_base_c, cks_n_c;
  logic [4:0]       mod_dec_c;

  // Download edge detection and write qualification.
  assign dl_rise_c = ioctl.ioctl_download & ~dl_q;
  assign dl_fall_c = ~ioctl.ioctl_download & dl_q;
  assign wr_acc_c  = ioctl.ioctl_wr & ioctl.ioctl_download;

  // Address map decode for index-0 writes.
  always_comb begin
    sel_cpu_c = 1'b0;
    sel_snd_c = 1'b0;
    sel_wav_c = 1'b0;
    if (wr_acc_c && (ioctl.ioctl_index == 8'd0)) begin
      sel_cpu_c = (ioctl.ioctl_addr[24:15] == 10'd0);
      sel_snd_c = (ioctl.ioctl_addr[24:12] == 13'h00E);
      sel_wav_c = (ioctl.ioctl_addr[24:16] == 9'h001);
    end
    in_map_c = sel_cpu_c | sel_snd_c | sel_wav_c;
  end

  // Load statistics: clear on an index-0 download start, then count the same-cycle write.
  always_comb begin
    bc_base_c  = byte_count;
    cks_base_c = checksum;
    if (dl_rise_c && (ioctl.ioctl_index == 8'd0)) begin
      bc_base_c  = '0;
      cks_base_c = '0;
    end
    bc_n_c  = bc_base_c;
    cks_n_c = cks_base_c;
    if (in_map_c) begin
      bc_n_c  = (bc_base_c == BC_MAX) ? BC_MAX : bc_base_c + BC_W'(1);
      cks_n_c = cks_base_c + ioctl.ioctl_dout;
    end
  end

  // Game select one-hot decode.
  always_comb begin
    mod_dec_c = 5'b00000;
    case (mod_q)
      8'd0:    mod_dec_c = 5'b00001;
      8'd1:    mod_dec_c = 5'b00010;
      8'd2:    mod_dec_c = 5'b00100;
      8'd3:    mod_dec_c = 5'b01000;
      8'd4:    mod_dec_c = 5'b10000;
      default: mod_dec_c = 5'b00000;
    endcase
  end

  // Next-state and hold counter.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (dl_rise_c) state_n = LOAD;
      end
      LOAD: begin
        if (dl_fall_c) begin
          state_n = HOLD;
          cnt_n   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (dl_rise_c)             state_n = LOAD;
        else if (cnt_q == '0)      state_n = READY;
        else                       cnt_n   = cnt_q - CNT_W'(1);
      end
      READY: begin
        if (dl_rise_c) state_n = LOAD;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; download history resets high so a level already high is not an edge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dl_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      dl_q    <= ioctl.ioctl_download;
    end
  end

  // Registered ROM write ports; address/data hold when no strobe.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_rom_we   <= 1'b0;
      snd_rom_we   <= 1'b0;
      wav_rom_we   <= 1'b0;
      cpu_rom_addr <= '0;
      snd_rom_addr <= '0;
      wav_rom_addr <= '0;
      rom_data     <= '0;
    end else begin
      cpu_rom_we <= sel_cpu_c;
      snd_rom_we <= sel_snd_c;
      wav_rom_we <= sel_wav_c;
      if (sel_cpu_c) cpu_rom_addr <= ioctl.ioctl_addr[14:0];
      if (sel_snd_c) snd_rom_addr <= ioctl.ioctl_addr[11:0];
      if (sel_wav_c) wav_rom_addr <= ioctl.ioctl_addr[15:0];
      if (in_map_c)  rom_data     <= ioctl.ioctl_dout;
    end
  end

  // Configuration bytes and game select.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dip_sw   <= '0;
      mod_q    <= '0;
      game_mod <= 5'b00001;
    end else begin
      if (wr_acc_c && (ioctl.ioctl_index == 8'd254) && (ioctl.ioctl_addr == 25'd0))
        dip_sw <= ioctl.ioctl_dout;
      if (wr_acc_c && (ioctl.ioctl_index == 8'd1) && (ioctl.ioctl_addr == 25'd0))
        mod_q <= ioctl.ioctl_dout;
      game_mod <= mod_dec_c;
    end
  end

  // Load status registers, aligned with the state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      byte_count <= '0;
      checksum   <= '0;
      core_hold  <= 1'b1;
      rom_valid  <= 1'b0;
    end else begin
      byte_count <= bc_n_c;
      checksum   <= cks_n_c;
      core_hold  <= (state_n != READY);
      rom_valid  <= (state_n == READY) && (bc_n_c != '0);
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: routing, status counters, hold timing,
// config bytes and reset behaviour, with hand-computed expectations.
module tb_rom_loader;

  logic        clk_sys;
  logic        reset;
  logic        cpu_rom_we, snd_rom_we, wav_rom_we;
  logic [14:0] cpu_rom_addr;
  logic [11:0] snd_rom_addr;
  logic [15:0] wav_rom_addr;
  logic [7:0]  rom_data, dip_sw, checksum;
  logic [4:0]  game_mod;
  logic        core_hold, rom_valid;
  logic [17:0] byte_count;

  int n_vec = 0;
  int n_err = 0;

  rom_loader_if ioctl_bus ();

  rom_loader #(.HOLD_CYCLES(4)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl        (ioctl_bus),
    .cpu_rom_we   (cpu_rom_we),
    .cpu_rom_addr (cpu_rom_addr),
    .snd_rom_we   (snd_rom_we),
    .snd_rom_addr (snd_rom_addr),
    .wav_rom_we   (wav_rom_we),
    .wav_rom_addr (wav_rom_addr),
    .rom_data     (rom_data),
    .dip_sw       (dip_sw),
    .game_mod     (game_mod),
    .core_hold    (core_hold),
    .rom_valid    (rom_valid),
    .byte_count   (byte_count),
    .checksum     (checksum)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] we_vec();
    return 32'({cpu_rom_we, snd_rom_we, wav_rom_we});
  endfunction

  task automatic start_dl(input logic [7:0] idx);
    ioctl_bus.ioctl_index    = idx;
    ioctl_bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_bus.ioctl_addr = a;
    ioctl_bus.ioctl_dout = d;
    ioctl_bus.ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_bus.ioctl_wr   = 1'b0;
  endtask

  // Drop download and measure how many cycles core_hold stays high in HOLD.
  task automatic finish_dl(input string tag);
    int n;
    n = 0;
    ioctl_bus.ioctl_download = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (!core_hold) break;
      n++;
    end
    chk({tag, "_hold_len"}, 32'(n), 32'd4);
    chk({tag, "_hold_rel"}, 32'(core_hold), 32'd0);
  endtask

  // Boundary routing table: addr, data, expected {cpu,snd,wav}, expected port addr.
  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
    logic [2:0]  we;
    logic [15:0] pa;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{25'h07FFF, 8'h01, 3'b100, 16'h7FFF};
    tbl[1] = '{25'h08000, 8'h02, 3'b000, 16'h0000};
    tbl[2] = '{25'h0DFFF, 8'h04, 3'b000, 16'h0000};
    tbl[3] = '{25'h0E000, 8'h08, 3'b010, 16'h0000};
    tbl[4] = '{25'h0EFFF, 8'h10, 3'b010, 16'h0FFF};
    tbl[5] = '{25'h0F000, 8'h20, 3'b000, 16'h0000};
    tbl[6] = '{25'h10000, 8'h40, 3'b001, 16'h0000};
    tbl[7] = '{25'h1FFFF, 8'h80, 3'b001, 16'hFFFF};
    tbl[8] = '{25'h20000, 8'h03, 3'b000, 16'h0000};

    ioctl_bus.ioctl_download = 1'b0;
    ioctl_bus.ioctl_wr       = 1'b0;
    ioctl_bus.ioctl_index    = 8'd0;
    ioctl_bus.ioctl_addr     = '0;
    ioctl_bus.ioctl_dout     = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);

    // Reset state
    chk("rst_we",        we_vec(),             32'd0);
    chk("rst_core_hold", 32'(core_hold),       32'd1);
    chk("rst_game_mod",  32'(game_mod),        32'h01);
    chk("rst_valid",     32'(rom_valid),       32'd0);
    chk("rst_bc",        32'(byte_count),      32'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Basic CPU write
    start_dl(8'd0);
    chk("load_hold", 32'(core_hold), 32'd1);
    write_byte(25'h00010, 8'hA5);
    chk("cpu_we",   we_vec(),            32'b100);
    chk("cpu_addr", 32'(cpu_rom_addr),   32'h0010);
    chk("cpu_data", 32'(rom_data),       32'hA5);
    chk("cpu_bc",   32'(byte_count),     32'd1);
    chk("cpu_cks",  32'(checksum),       32'hA5);
    @(negedge clk_sys);
    chk("cpu_we_off",  we_vec(),         32'd0);
    chk("data_hold",   32'(rom_data),    32'hA5);

    // Sound and sample writes, then an unmapped one
    write_byte(25'h0E123, 8'h11);
    chk("snd_we",   we_vec(),            32'b010);
    chk("snd_addr", 32'(snd_rom_addr),   32'h123);
    chk("snd_bc",   32'(byte_count),     32'd2);
    write_byte(25'h1ABCD, 8'h22);
    chk("wav_we",   we_vec(),            32'b001);
    chk("wav_addr", 32'(wav_rom_addr),   32'hABCD);
    chk("wav_cks",  32'(checksum),       32'hD8);
    write_byte(25'h09000, 8'h33);
    chk("gap_we",   we_vec(),            32'd0);
    chk("gap_bc",   32'(byte_count),     32'd3);
    chk("gap_data", 32'(rom_data),       32'h22);
    chk("gap_cks",  32'(checksum),       32'hD8);

    finish_dl("dl0");
    chk("dl0_valid", 32'(rom_valid), 32'd1);

    // Game select via index 1
    start_dl(8'd1);
    chk("idx1_valid", 32'(rom_valid), 32'd0);
    write_byte(25'h0, 8'h04);
    chk("idx1_we", we_vec(), 32'd0);
    @(negedge clk_sys);
    chk("mod4", 32'(game_mod), 32'b10000);
    write_byte(25'h0, 8'h07);
    @(negedge clk_sys);
    chk("mod7", 32'(game_mod), 32'b00000);
    chk("idx1_bc", 32'(byte_count), 32'd3);
    finish_dl("dl1");

    // DIP bank via index 254
    start_dl(8'd254);
    write_byte(25'h0, 8'h80);
    write_byte(25'h3, 8'hFF);
    @(negedge clk_sys);
    chk("dip", 32'(dip_sw), 32'h80);
    finish_dl("dl254");
    chk("dl254_valid", 32'(rom_valid), 32'd1);

    // 100 bytes then reset during an in-flight write
    start_dl(8'd0);
    for (int i = 0; i < 100; i++) write_byte(25'(i), 8'(i));
    chk("b100_bc",  32'(byte_count), 32'd100);
    chk("b100_cks", 32'(checksum),   32'h56);
    ioctl_bus.ioctl_addr = 25'h64;
    ioctl_bus.ioctl_dout = 8'hEE;
    ioctl_bus.ioctl_wr   = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_bc",   32'(byte_count), 32'd0);
    chk("mid_rst_hold", 32'(core_hold),  32'd1);
    chk("mid_rst_mod",  32'(game_mod),   32'h01);
    chk("mid_rst_dip",  32'(dip_sw),     32'h00);
    @(posedge clk_sys);
    #1;
    chk("mid_rst_we",   we_vec(),        32'd0);
    @(negedge clk_sys);
    ioctl_bus.ioctl_wr = 1'b0;
    reset = 1'b0;
    // Download still high: must stay idle without an edge
    repeat (3) @(negedge clk_sys);
    chk("post_rst_hold", 32'(core_hold), 32'd1);
    chk("post_rst_bc",   32'(byte_count), 32'd0);
    ioctl_bus.ioctl_download = 1'b0;
    repeat (8) @(negedge clk_sys);
    chk("idle_hold", 32'(core_hold), 32'd1);

    // Address map boundaries after restart
    start_dl(8'd0);
    for (int i = 0; i < 9; i++) begin
      write_byte(tbl[i].a, tbl[i].d);
      chk($sformatf("map%0d_we", i), we_vec(), 32'(tbl[i].we));
      if (tbl[i].we == 3'b100) chk($sformatf("map%0d_a", i), 32'(cpu_rom_addr), 32'(tbl[i].pa));
      if (tbl[i].we == 3'b010) chk($sformatf("map%0d_a", i), 32'(snd_rom_addr), 32'(tbl[i].pa));
      if (tbl[i].we == 3'b001) chk($sformatf("map%0d_a", i), 32'(wav_rom_addr), 32'(tbl[i].pa));
    end
    chk("map_bc",  32'(byte_count), 32'd5);
    chk("map_cks", 32'(checksum),   32'hD9);
    finish_dl("dlmap");

    // Write coincident with download rising edge: clear then count
    ioctl_bus.ioctl_index    = 8'd0;
    ioctl_bus.ioctl_download = 1'b1;
    write_byte(25'h00005, 8'h10);
    chk("co_we",  we_vec(),          32'b100);
    chk("co_bc",  32'(byte_count),   32'd1);
    chk("co_cks", 32'(checksum),     32'h10);
    finish_dl("dlco");
    chk("co_valid", 32'(rom_valid), 32'd1);

    // Empty index-0 download ends with no valid ROM
    start_dl(8'd0);
    chk("empty_bc", 32'(byte_count), 32'd0);
    finish_dl("dlempty");
    chk("empty_valid", 32'(rom_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 256: clk_sys cycles that core_hold stays high after a download ends.
REQ-002 SHALL have port clk_sys, input, 1 bit: the single system clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have inputs ioctl_download (1), ioctl_wr (1), ioctl_index (8), ioctl_addr (25) and ioctl_dout (8): the HPS download stream.
REQ-005 SHALL have outputs cpu_rom_we (1) and cpu_rom_addr (15): main CPU ROM write port.
REQ-006 SHALL have outputs snd_rom_we (1) and snd_rom_addr (12): sound CPU ROM write port.
REQ-007 SHALL have outputs wav_rom_we (1) and wav_rom_addr (16): sample ROM write port.
REQ-008 SHALL have output rom_data (8): write data shared by all three ROM ports.
REQ-009 SHALL have output dip_sw (8): DIP switch bank 0.
REQ-010 SHALL have output game_mod (5): one-hot game select; bit 0 dk, bit 1 dkjr, bit 2 dk3, bit 3 radarscope, bit 4 pestplace.
REQ-011 SHALL have output core_hold (1): reset request to the game core.
REQ-012 SHALL have outputs rom_valid (1), byte_count (18) and checksum (8): load status.

Function
REQ-013 SHALL treat an accepted write as ioctl_wr=1 with ioctl_download=1, sampled on a clk_sys rising edge.
REQ-014 SHALL route index-0 writes by address:
  - 0x00000-0x07FFF: CPU ROM, cpu_rom_addr=addr[14:0].
  - 0x0E000-0x0EFFF: sound ROM, snd_rom_addr=addr[11:0].
  - 0x10000-0x1FFFF: sample ROM, wav_rom_addr=addr[15:0].
  - Any other address: discarded, with no strobe.
REQ-015 SHALL register all ROM outputs, so each strobe is high for exactly 1 cycle, 1 cycle after the accepted write, with matching address and rom_data.
REQ-016 SHALL never assert more than one *_rom_we in the same cycle.
REQ-017 SHALL hold rom_data and the address outputs at their last values when no strobe is active.
REQ-018 SHALL load an index-254 write with addr==0 into dip_sw; other index-254 addresses are ignored.
REQ-019 SHALL load an index-1 write with addr==0 into an internal 8-bit mod register.
REQ-020 SHALL drive game_mod one-hot from mod values 0-4, registered 1 cycle after the mod register updates.
REQ-021 SHALL drive game_mod=00000 for mod values 5-255.
REQ-022 SHALL implement a state machine with states IDLE, LOAD, HOLD and READY.
REQ-023 SHALL apply these state transitions:
  - IDLE->LOAD on ioctl_download rising edge (any index).
  - LOAD->HOLD on ioctl_download falling edge; the hold counter loads HOLD_CYCLES-1.
  - HOLD decrements the counter each cycle and goes to READY in the cycle after it reaches 0.
  - HOLD or READY->LOAD on ioctl_download rising edge; the HOLD count is abandoned.
REQ-024 SHALL clear byte_count and checksum on entry to LOAD only when ioctl_index==0 at the rising edge.
REQ-025 SHALL, for each accepted in-map index-0 write, increment byte_count (saturating at 0x3FFFF) and add the data byte to checksum modulo 256.
REQ-026 SHALL make byte_count and checksum updates take effect in the same cycle as the ROM strobe.
REQ-027 SHALL drive core_hold=1 in IDLE, LOAD and HOLD, and core_hold=0 only in READY.
REQ-028 SHALL drive rom_valid=1 only in READY with byte_count!=0.
REQ-029 SHALL handle ioctl_wr arriving in the same cycle as the ioctl_download rising edge by accepting the write and counting it after the clear.
REQ-030 SHALL treat HOLD_CYCLES=0 as 1.

Reset
REQ-031 SHALL, on reset assertion, immediately set: state=IDLE; all *_we=0; all addresses, rom_data, dip_sw, mod register, byte_count and checksum=0; game_mod=00001; core_hold=1; rom_valid=0.
REQ-032 SHALL discard any in-flight write when reset asserts mid-download.
REQ-033 SHALL stay in IDLE after reset until the next ioctl_download rising edge, even if ioctl_download is already high when reset releases.

Verification
REQ-034 SHALL pass: index 0, write 0xA5 at 0x00010 -> next cycle cpu_rom_we=1, cpu_rom_addr=0x0010, rom_data=0xA5, byte_count=1, checksum=0xA5.
REQ-035 SHALL pass: index 0, writes at 0x0E123 and 0x1ABCD -> snd_rom_addr=0x123 strobe, then wav_rom_addr=0xABCD strobe; write at 0x09000 -> no strobe, byte_count unchanged.
REQ-036 SHALL pass: download falls with HOLD_CYCLES=4 -> core_hold=1 for 4 cycles of HOLD, then 0; rom_valid=1.
REQ-037 SHALL pass: index 1, data 0x04 -> game_mod=10000; data 0x07 -> game_mod=00000.
REQ-038 SHALL pass: index 254, addr 0 data 0x80, then addr 3 data 0xFF -> dip_sw=0x80.
REQ-039 SHALL pass: reset asserted mid-LOAD after 100 bytes -> byte_count=0, core_hold=1, no strobes; a new download restarts counting from 0.
